cache_ctrl: RTL

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_ctrl_if.sv | 32 +++
 rtl/cache_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_if.sv
// CPU / backing-memory bus of the cache controller. The controller sits on
// the slave side; the CPU and the BRAM stage together form the master side.
interface cache_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_ready;
    logic              cache_ram_valid;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic              bram_valid;
    logic [15:0]       hit_cnt;
    logic [15:0]       miss_cnt;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata, bram_valid,
        output cpu_rdata, cpu_ready, cache_ram_valid, ram_we, ram_addr,
               ram_wdata, hit_cnt, miss_cnt
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata, bram_valid,
        input  cpu_rdata, cpu_ready, cache_ram_valid, ram_we, ram_addr,
               ram_wdata, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-back / write-allocate cache controller with one
// 32-bit word per line. Every output is a register loaded from the
// next-state logic, so the bus sees clean pulses one cycle after a decision.
module cache_ctrl #(
    parameter int ADDR_W  = 10,
    parameter int INDEX_W = 4
) (
    input  logic        cpu_clk,
    input  logic        rst,
    cache_ctrl_if.slave bus
);
    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

    state_t state, state_nx;

    // Latched request
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              first_pass, first_nx;

    // Line storage
    logic [LINES-1:0]  valid_q, dirty_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [31:0]       data_q [LINES];

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic               hit;

    // Next values of the registered outputs and storage write strobes
    logic              latch, wr_hit, fill;
    logic              ready_nx, rvalid_nx, ram_we_nx;
    logic [31:0]       rdata_nx, ram_wdata_nx;
    logic [ADDR_W-1:0] ram_addr_nx;
    logic [15:0]       hit_nx, miss_nx;

    assign idx = req_addr[INDEX_W-1:0];
    assign tag = req_addr[ADDR_W-1:INDEX_W];
    assign hit = valid_q[idx] && (tag_q[idx] == tag);

    // State register plus every externally visible register
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            req_we              <= 1'b0;
            req_addr            <= '0;
            req_wdata           <= '0;
            first_pass          <= 1'b0;
            valid_q             <= '0;
            dirty_q             <= '0;
            bus.cpu_ready       <= 1'b0;
            bus.cpu_rdata       <= '0;
            bus.cache_ram_valid <= 1'b0;
            bus.ram_we          <= 1'b0;
            bus.ram_addr        <= '0;
            bus.ram_wdata       <= '0;
            bus.hit_cnt         <= '0;
            bus.miss_cnt        <= '0;
        end else begin
            state               <= state_nx;
            first_pass          <= first_nx;
            bus.cpu_ready       <= ready_nx;
            bus.cpu_rdata       <= rdata_nx;
            bus.cache_ram_valid <= rvalid_nx;
            bus.ram_we          <= ram_we_nx;
            bus.ram_addr        <= ram_addr_nx;
            bus.ram_wdata       <= ram_wdata_nx;
            bus.hit_cnt         <= hit_nx;
            bus.miss_cnt        <= miss_nx;
            if (latch) begin
                req_we    <= bus.cpu_we;
                req_addr  <= bus.cpu_addr;
                req_wdata <= bus.cpu_wdata;
            end
            if (wr_hit) dirty_q[idx] <= 1'b1;
            if (fill) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end
        end
    end

    // Line payload; needs no reset because valid_q gates its use
    always_ff @(posedge cpu_clk) begin
        if (wr_hit) data_q[idx] <= req_wdata;
        if (fill) begin
            data_q[idx] <= bus.ram_rdata;
            tag_q[idx]  <= tag;
        end
    end

    // Next-state and next-output decisions
    always_comb begin
        state_nx     = state;
        first_nx     = first_pass;
        latch        = 1'b0;
        wr_hit       = 1'b0;
        fill         = 1'b0;
        ready_nx     = 1'b0;
        rvalid_nx    = 1'b0;
        rdata_nx     = bus.cpu_rdata;
        ram_we_nx    = bus.ram_we;
        ram_addr_nx  = bus.ram_addr;
        ram_wdata_nx = bus.ram_wdata;
        hit_nx       = bus.hit_cnt;
        miss_nx      = bus.miss_cnt;
        unique case (state)
            IDLE: begin
                if (bus.cpu_req) begin
                    latch    = 1'b1;
                    first_nx = 1'b1;
                    state_nx = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    ready_nx = 1'b1;
                    state_nx = IDLE;
                    if (req_we) wr_hit   = 1'b1;
                    else        rdata_nx = data_q[idx];
                    // The post-fill re-compare is not a real hit
                    if (first_pass && bus.hit_cnt != 16'hFFFF)
                        hit_nx = bus.hit_cnt + 16'd1;
                end else begin
                    first_nx  = 1'b0;
                    rvalid_nx = 1'b1;
                    if (first_pass && bus.miss_cnt != 16'hFFFF)
                        miss_nx = bus.miss_cnt + 16'd1;
                    if (valid_q[idx] && dirty_q[idx]) begin
                        state_nx     = WRITEBACK;
                        ram_we_nx    = 1'b1;
                        ram_addr_nx  = {tag_q[idx], idx};
                        ram_wdata_nx = data_q[idx];
                    end else begin
                        state_nx    = ALLOCATE;
                        ram_we_nx   = 1'b0;
                        ram_addr_nx = req_addr;
                    end
                end
            end
            WRITEBACK: begin
                if (bus.bram_valid) begin
                    state_nx    = ALLOCATE;
                    rvalid_nx   = 1'b1;
                    ram_we_nx   = 1'b0;
                    ram_addr_nx = req_addr;
                end
            end
            ALLOCATE: begin
                if (bus.bram_valid) begin
                    fill     = 1'b1;
                    state_nx = COMPARE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule
